// File: rtl/srm_ctrl_pkg.sv
// Shared types and encodings for the simple RISC machine controller: FSM states,
// opcode/op values, writeback selects and instruction-register field positions.
package srm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    NSEL_NONE,
    NSEL_RN,
    NSEL_RD,
    NSEL_RM
  } nsel_t;

  // Instruction class after looking at opcode and op together
  typedef enum logic [2:0] {
    C_NONE,
    C_MOV_IMM,
    C_MOV_REG,
    C_ADD_AND,
    C_CMP,
    C_MVN,
    C_HALT
  } cls_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM8_W  = 8;

  function automatic cls_t classify(input logic [2:0] opcode, input logic [1:0] op);
    cls_t c;
    c = C_NONE;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      c = C_MOV_IMM;
      else if (op == OP_MOV_REG) c = C_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD, OP_AND: c = C_ADD_AND;
        OP_CMP:         c = C_CMP;
        OP_MVN:         c = C_MVN;
        default:        c = C_NONE;
      endcase
    end else if (opcode == OPC_HALT) begin
      c = C_HALT;
    end
    return c;
  endfunction

endpackage

// File: rtl/srm_controller_if.sv
// Instruction handshake and datapath control bundle between the controller (slave)
// and whoever feeds it instructions and consumes its control signals (master).
interface srm_controller_if #(
  parameter int DW = 16
);
  logic          s;
  logic [DW-1:0] in;
  logic          w;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic [1:0]    vsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic [DW-1:0] sximm8;

  modport master (
    output s, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, sximm8
  );

  modport slave (
    input  s, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, sximm8
  );
endinterface

// File: rtl/srm_instr_decode.sv
// Combinational instruction field extraction: opcode/op, shift, sign-extended imm8
// and the register index selected by nsel.
module srm_instr_decode
  import srm_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] ir,
  input  nsel_t         nsel,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [1:0]    shift,
  output logic [2:0]    regnum,
  output logic [DW-1:0] sximm8
);

  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;

  assign opcode = ir[OPC_LSB +: 3];
  assign op     = ir[OP_LSB +: 2];
  assign rn     = ir[RN_LSB +: 3];
  assign rd     = ir[RD_LSB +: 3];
  assign shift  = ir[SH_LSB +: 2];
  assign rm     = ir[RM_LSB +: 3];

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_sx
      if (gi < IMM8_W) begin : g_low
        assign sximm8[gi] = ir[gi];
      end else begin : g_ext
        assign sximm8[gi] = ir[IMM8_W-1];
      end
    end
  endgenerate

  always_comb begin
    regnum = 3'd0;
    case (nsel)
      NSEL_RN: regnum = rn;
      NSEL_RD: regnum = rd;
      NSEL_RM: regnum = rm;
      default: regnum = 3'd0;
    endcase
  end

endmodule

// File: rtl/srm_controller.sv
// Multi-cycle controller for the simple RISC machine: latches an instruction on s and
// sequences datapath enables. Define SRM_CTRL_HALT_EN to make opcode 111 halt until reset.
module srm_controller
  import srm_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             reset,
  srm_controller_if.slave  bus
);

  state_t        state_reg, state_next;
  logic [DW-1:0] ir_reg;
  logic          ir_load;
  nsel_t         nsel;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [1:0]    shift;
  logic [2:0]    regnum;
  logic [DW-1:0] sximm8;
  cls_t          cls;

  assign ir_load = (state_reg == S_WAIT) && bus.s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ir_reg <= '0;
    else if (ir_load) ir_reg <= bus.in;
  end

  srm_instr_decode #(.DW(DW)) u_decode (
    .ir     (ir_reg),
    .nsel   (nsel),
    .opcode (opcode),
    .op     (op),
    .shift  (shift),
    .regnum (regnum),
    .sximm8 (sximm8)
  );

  assign cls = classify(opcode, op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_WAIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:   if (bus.s) state_next = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_MOV_IMM:        state_next = S_WR_IMM;
          C_MOV_REG, C_MVN: state_next = S_GET_B;
          C_ADD_AND, C_CMP: state_next = S_GET_A;
`ifdef SRM_CTRL_HALT_EN
          C_HALT:           state_next = S_HALT;
`endif
          default:          state_next = S_WAIT;
        endcase
      end
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_EXEC;
      // CMP only updates status, so it skips writeback
      S_EXEC:   state_next = (cls == C_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_next = S_WAIT;
      S_WR_IMM: state_next = S_WAIT;
`ifdef SRM_CTRL_HALT_EN
      S_HALT:   state_next = S_HALT;
`endif
      default:  state_next = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w     = 1'b0;
    bus.write = 1'b0;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.asel  = 1'b0;
    bus.vsel  = VSEL_C;
    nsel      = NSEL_NONE;
    case (state_reg)
      S_WAIT:  bus.w = 1'b1;
      S_GET_A: begin
        nsel      = NSEL_RN;
        bus.loada = 1'b1;
      end
      S_GET_B: begin
        nsel      = NSEL_RM;
        bus.loadb = 1'b1;
      end
      S_EXEC: begin
        bus.loads = (cls == C_CMP);
        bus.loadc = (cls != C_CMP);
        // MOV reg passes B through the ALU by zeroing A
        bus.asel  = (cls == C_MOV_REG);
      end
      S_WR_REG: begin
        nsel      = NSEL_RD;
        bus.write = 1'b1;
      end
      S_WR_IMM: begin
        nsel      = NSEL_RN;
        bus.vsel  = VSEL_IMM8;
        bus.write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.bsel     = 1'b0;
  assign bus.readnum  = regnum;
  assign bus.writenum = regnum;
  assign bus.shift    = shift;
  assign bus.ALUop    = op;
  assign bus.sximm8   = sximm8;

endmodule

// File: doc/srm_controller.md
SRM_CONTROLLER -- requirements
Module: srm_controller

Interface
REQ-001 Parameter: DW, 16, instruction and datapath word width; sximm8 is sign-extended to DW.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: s  input  1  start; sampled only in WAIT.
REQ-005 Port: in  input  DW  instruction word; latched into IR when s is sampled.
REQ-006 Port: w  output  1  high only in WAIT, meaning ready for the next instruction.
REQ-007 Port: readnum, writenum  output  3 each  register-file read and write index; both carry the same nsel-selected field.
REQ-008 Port: write  output  1  register-file write enable.
REQ-009 Port: loada, loadb, loadc, loads  output  1 each  datapath A, B, C and status register load enables.
REQ-010 Port: asel, bsel  output  1 each  asel=1 forces the ALU A input to zero; bsel=1 selects sximm5 (tied off, always 0 here).
REQ-011 Port: vsel  output  2  writeback source: 00 = ALU C, 01 = sximm8, 10 and 11 reserved and never driven.
REQ-012 Port: shift, ALUop  output  2 each  taken from IR[4:3] and IR[12:11].
REQ-013 Port: sximm8  output  DW  IR[7:0] sign-extended.

Function
REQ-014 IR field map: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0].
REQ-015 FSM states: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, HALT.
REQ-016 WAIT with s=1: on the next edge, IR <= in and the state goes to DECODE; s is ignored in every other state.
REQ-017 From DECODE, opcode/op select the path:
- 110/10 MOV imm: WR_IMM -> WAIT
- 110/00 MOV reg: GET_B -> EXEC (asel=1) -> WR_REG -> WAIT
- 101/00 ADD and 101/10 AND: GET_A -> GET_B -> EXEC -> WR_REG -> WAIT
- 101/01 CMP: GET_A -> GET_B -> EXEC -> WAIT
- 101/11 MVN: GET_B -> EXEC -> WR_REG -> WAIT
REQ-018 GET_A drives nsel=Rn and loada=1; GET_B drives nsel=Rm and loadb=1.
REQ-019 EXEC drives loadc=1 for all operations except CMP; CMP drives loads=1 and loadc=0.
REQ-020 WR_REG drives nsel=Rd, vsel=00, write=1; WR_IMM drives nsel=Rn, vsel=01, write=1.
REQ-021 Outputs are Moore, a function of state and IR only; every enable not listed for the current state is 0, and readnum/writenum are 0 in WAIT.
REQ-022 Latency, counted in edges from the edge that samples s until w returns high: MOV imm 3, MOV reg 5, ADD/AND 6, CMP 5, MVN 5.
REQ-023 Any unlisted opcode/op combination goes DECODE -> WAIT with no enable asserted.
REQ-024 s held high continuously starts a new instruction each time WAIT is re-entered.

Reset
REQ-025 reset=1 forces state=WAIT and IR=0 immediately, including mid-instruction; all enables go to 0 and w=1.
REQ-026 A register-file write pending in WR_REG/WR_IMM is suppressed when reset is asserted before its edge.

Configuration
REQ-027 Macro SRM_CTRL_HALT_EN: when defined, opcode 111 goes DECODE -> HALT; HALT holds with w=0 and all enables 0 until reset. When undefined, opcode 111 is treated as illegal per REQ-023.

Structure
REQ-028 Package srm_ctrl_pkg holds the state enum, opcode/op localparams, vsel encodings and the IR field bit positions.
REQ-029 One sub-module, srm_instr_decode: purely combinational field extraction, sign extension and nsel muxing; IR uses the team's existing load-enable register.

Verification
REQ-030 in=16'hD105 (MOV R1,#5) with s pulsed: write=1 with writenum=1, vsel=01, sximm8=16'h0005 in WR_IMM; w high 3 edges after s is sampled.
REQ-031 in=16'hA0A1 (ADD R5,R0,R1): readnum sequence 0 then 1 with loada/loadb, then loadc, then writenum=5 with write=1; w=1 after 6 edges.
REQ-032 in=16'hA903 (CMP R1,R3): loads=1 in EXEC; write and loadc never asserted.
REQ-033 reset asserted during GET_B of an ADD: state WAIT and w=1 immediately; no write occurs; the next MOV executes normally.
REQ-034 in=16'hE000 with s=1: with SRM_CTRL_HALT_EN defined, w stays 0 indefinitely until reset; without it, w=1 after 2 edges and no enables are asserted.
